// File: rtl/arb2_sel.sv
// Two-input round-robin packet arbiter that drives a 2:1 mux select and forwards the granted stream.
// Latency: one registered output stage. Backpressure: granted ready = ~out_valid | out_ready; ungranted ready = 0.
module arb2_sel #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_data,
    input  logic         in0_last,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         Sel
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           sel_q, sel_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           out_free;

    // The output slot can take a beat when empty or when it drains this cycle.
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                    sel_d   = ptr_q;
                end else if (in0_valid) begin
                    state_d = GRANT0;
                    sel_d   = 1'b0;
                end else if (in1_valid) begin
                    state_d = GRANT1;
                    sel_d   = 1'b1;
                end
            end
            GRANT0: begin
                in0_ready = out_free;
                if (in0_valid && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in0_data;
                    out_last_d  = in0_last;
                    if (in0_last) begin
                        state_d = IDLE;
                        ptr_d   = 1'b1;
                    end
                end
            end
            GRANT1: begin
                in1_ready = out_free;
                if (in1_valid && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in1_data;
                    out_last_d  = in1_last;
                    if (in1_last) begin
                        state_d = IDLE;
                        ptr_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign Sel       = sel_q;

endmodule

// File: tb/tb_arb2_sel.sv
// Directed bench for arb2_sel: per-channel source queues feed the DUT, a scoreboard of expected
// output beats (pushed in expected arbitration order) is popped by a negedge output monitor.
module tb_arb2_sel;
    localparam int W = 8;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid, in0_ready, in0_last;
    logic [W-1:0] in0_data;
    logic         in1_valid, in1_ready, in1_last;
    logic [W-1:0] in1_data;
    logic         out_valid, out_ready, out_last;
    logic [W-1:0] out_data;
    logic         Sel;

    beat_t q0[$], q1[$], exp_q[$];
    beat_t mon_e;
    logic  gate0, gate1, hs0, hs1;
    int    n_cmp = 0;
    int    n_err = 0;

    logic [11:0] sel_pat = 12'b111000111000;
    logic [1:0]  rdy_pat [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                  2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

    arb2_sel #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .Sel(Sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, req);
        end
    endtask

    task automatic apply();
        in0_valid = (q0.size() > 0) && !gate0;
        in1_valid = (q1.size() > 0) && !gate1;
        if (q0.size() > 0) begin
            in0_data = q0[0].data;
            in0_last = q0[0].last;
        end
        if (q1.size() > 0) begin
            in1_data = q1[0].data;
            in1_last = q1[0].last;
        end
    endtask

    // Handshakes are sampled mid-cycle; the accepted head is retired just after the edge.
    task automatic cyc();
        @(negedge clk);
        hs0 = in0_valid & in0_ready;
        hs1 = in1_valid & in1_ready;
        @(posedge clk);
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        apply();
    endtask

    task automatic push(input int ch, input logic [W-1:0] d, input logic l, input logic expect_out);
        beat_t b;
        b.data = d;
        b.last = l;
        if (ch == 0) q0.push_back(b);
        else         q1.push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0); i++) cyc();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        gate0 = 1'b0;
        gate1 = 1'b0;
        out_ready = 1'b1;
        apply();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL sb_extra: got %0h want no beat", out_data);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.data));
                chk("out_last", 32'(out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        out_ready = 1'b1;
        gate0 = 1'b0; gate1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_sel",       32'(Sel),       32'd0);
        chk("rst_rdy",       32'({in1_ready, in0_ready}), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Three-beat packet on channel 0 at full rate.
        push(0, 8'h11, 1'b0, 1'b1);
        push(0, 8'h22, 1'b0, 1'b1);
        push(0, 8'h33, 1'b1, 1'b1);
        apply();
        cyc();
        #1;
        chk("t1_sel", 32'(Sel), 32'd0);
        chk("t1_rdy0", 32'(in0_ready), 32'd1);
        repeat (4) cyc();
        #1;
        chk("t1_consecutive", 32'(exp_q.size()), 32'd0);
        chk("t1_idle_rdy", 32'({in1_ready, in0_ready}), 32'd0);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        drain("t1_drain");

        // Both channels always requesting: strict alternation with one idle cycle between packets.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            push(0, 8'hA0, 1'b0, 1'b1);
            push(0, 8'hA1, 1'b1, 1'b1);
            push(1, 8'hB0, 1'b0, 1'b1);
            push(1, 8'hB1, 1'b1, 1'b1);
        end
        apply();
        for (int k = 0; k < 12; k++) begin
            cyc();
            #1;
            chk($sformatf("t2_sel_%0d", k), 32'(Sel), 32'(sel_pat[k]));
            chk($sformatf("t2_rdy_%0d", k), 32'({in1_ready, in0_ready}), 32'(rdy_pat[k]));
        end
        drain("t2_drain");

        // Channel 1 stalls mid-packet while channel 0 requests: grant must stay locked.
        push(1, 8'hC0, 1'b0, 1'b1);
        push(1, 8'hC1, 1'b0, 1'b1);
        push(1, 8'hC2, 1'b1, 1'b1);
        apply();
        cyc();
        cyc();
        gate1 = 1'b1;
        push(0, 8'hD0, 1'b0, 1'b1);
        push(0, 8'hD1, 1'b1, 1'b1);
        apply();
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            chk("t3_rdy0_locked", 32'(in0_ready), 32'd0);
            chk("t3_sel_locked", 32'(Sel), 32'd1);
        end
        gate1 = 1'b0;
        apply();
        drain("t3_drain");

        // Output backpressure for three cycles while 0x5A is held.
        push(0, 8'h5A, 1'b0, 1'b1);
        push(0, 8'h5B, 1'b0, 1'b1);
        push(0, 8'h5C, 1'b1, 1'b1);
        apply();
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk("t4_hold_data", 32'(out_data), 32'h5A);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_rdy0_blocked", 32'(in0_ready), 32'd0);
        end
        out_ready = 1'b1;
        drain("t4_drain");

        // Single-beat packet on channel 1 returns straight to IDLE.
        push(1, 8'hE1, 1'b1, 1'b1);
        apply();
        cyc();
        cyc();
        #1;
        chk("t5_single_data", 32'(out_data), 32'hE1);
        chk("t5_single_last", 32'(out_last), 32'd1);
        chk("t5_single_idle", 32'({in1_ready, in0_ready}), 32'd0);
        drain("t5_drain");

        // Asynchronous reset mid-packet drops the rest of the packet.
        push(1, 8'hF0, 1'b0, 1'b0);
        push(1, 8'hF1, 1'b0, 1'b0);
        push(1, 8'hF2, 1'b1, 1'b0);
        apply();
        cyc();
        cyc();
        #1;
        chk("t6_pre_sel", 32'(Sel), 32'd1);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_sel", 32'(Sel), 32'd0);
        chk("t6_async_rdy", 32'({in1_ready, in0_ready}), 32'd0);
        chk("t6_async_data", 32'(out_data), 32'd0);
        q1.delete();
        apply();
        cyc();
        cyc();
        push(0, 8'h60, 1'b0, 1'b1);
        push(0, 8'h61, 1'b1, 1'b1);
        push(1, 8'h70, 1'b0, 1'b1);
        push(1, 8'h71, 1'b1, 1'b1);
        rst_n = 1'b1;
        apply();
        cyc();
        #1;
        chk("t6_first_sel", 32'(Sel), 32'd0);
        chk("t6_first_rdy", 32'({in1_ready, in0_ready}), 32'b01);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb2_sel.md
# arb2_sel

Two-input round-robin packet arbiter that sits directly upstream of the team's 2:1 mux. It accepts two valid/ready streams and grants one at a time, holding the grant for a whole packet (through the beat flagged `last`). It drives the mux select `Sel` and forwards the granted stream through a single registered output stage. Downstream logic sees one in-order, non-interleaved packet stream.

## Interface
- `W`, default 8: data width per beat.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in0_valid`  in  1: channel 0 beat present.
- `in0_ready`  out  1: channel 0 beat accepted when high with `in0_valid`.
- `in0_data`  in  W: channel 0 beat data.
- `in0_last`  in  1: channel 0 final beat of packet.
- `in1_valid`, `in1_ready`, `in1_data`, `in1_last`: same as channel 0, for channel 1.
- `out_valid`  out  1: registered output beat present.
- `out_ready`  in  1: downstream accepts the beat.
- `out_data`  out  W: registered beat data.
- `out_last`  out  1: registered last flag.
- `Sel`  out  1: registered mux select; 0 = channel 0, 1 = channel 1.
- Clock/reset: one clock; reset is asynchronous and active-low.

## Operation
- State machine: IDLE, GRANT0, GRANT1. Priority pointer `ptr` (1 bit).
- IDLE:
  - No valid input: stay in IDLE.
  - One valid input: next state is GRANT of that channel.
  - Both valid: grant channel `ptr`.
  - `Sel` loads the granted index on the same edge the state changes.
  - Both readies are 0 in IDLE.
- GRANTx:
  - `inx_ready = ~out_valid | out_ready`; the other channel's ready is 0.
  - An accepted beat (`inx_valid & inx_ready`) loads `out_data`/`out_last` and sets `out_valid` on the next edge.
  - An accepted beat with `last=1` moves the state to IDLE and sets `ptr = ~x`.
  - Grant is locked until `last`. The granted channel dropping `valid` mid-packet keeps the grant and inserts bubbles. The other channel is ignored.
- Output register:
  - `out_valid` clears on `out_ready` unless a new beat is accepted in the same cycle; in that case it reloads (full throughput).
  - `out_data`/`out_last` are stable while `out_valid & ~out_ready`.
- `Sel` changes only on an IDLE→GRANT transition. It holds its value in IDLE.

## Timing
- Reset values: state IDLE, `ptr`=0, `Sel`=0, `out_valid`=0, `out_data`=0, `out_last`=0, both readies 0.
- Reset asserted mid-packet aborts immediately:
  - All registers take reset values asynchronously; a partially forwarded packet is dropped.
  - The first grant after release follows normal arbitration.
- Grant latency: a valid input seen in IDLE at edge N gives GRANT and `Sel` after edge N. Ready is high in cycle N+1.
- Data latency: beat accepted at edge M gives `out_valid` after edge M (one cycle).
- Throughput: 1 beat/cycle within a packet while `out_ready`=1.
- Inter-packet gap: exactly one IDLE cycle between packets, with no ready on either channel.
- Backpressure: `out_ready`=0 with `out_valid`=1 forces the granted ready to 0 that cycle. No beat is lost or duplicated.
- Single-beat packet (`last` on the first beat): GRANT lasts one accepted beat, then IDLE.
- Simultaneous requests at every arbitration alternate 0,1,0,1… starting at 0 after reset.

## Test plan
- Reset, then `in0_valid`=1 with 3 beats 0x11,0x22,0x33 (last on 0x33), `out_ready`=1:
  - `Sel`=0 one cycle after valid.
  - `out_data` 0x11,0x22,0x33 on consecutive cycles, `out_last` only on 0x33.
  - State returns to IDLE.
- Both channels continuously valid, 2-beat packets (ch0 0xA0,0xA1; ch1 0xB0,0xB1):
  - Output order is A0,A1,B0,B1,A0,A1…
  - `Sel` toggles 0,1,0 with one idle cycle per packet boundary.
- During a ch1 packet, raise `in0_valid` and drop `in1_valid` for 2 cycles mid-packet:
  - Grant stays on ch1 and `in0_ready` stays 0.
  - Ch1 resumes, completes, and ch0 is granted next.
- `out_ready`=0 for 3 cycles while `out_valid`=1 holding 0x5A:
  - `out_data` stays 0x5A and the granted ready is 0.
  - After release, all beats emerge exactly once, in order.
- Assert `rst_n`=0 mid-packet:
  - `out_valid`, `Sel`, and readies drop to 0 without waiting for `clk`.
  - After release with both channels valid, channel 0 is granted first.
